// File: rtl/noc_rx_endpoint.sv
// NoC receive endpoint: header/payload deframer with destination filter,
// first-word-fall-through payload FIFO and ACK/NAK response channel.
module noc_rx_endpoint #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned MY_ID = 0,
  localparam int unsigned LW   = DW / 2,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CmdW,
  input  logic [DW-1:0] DataW,
  output logic          CmdR,
  output logic [DW-1:0] DataR,
  output logic          NakR,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [CW-1:0] level,
  output logic          frame_err,
  output logic [7:0]    drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [LW-1:0] ID = LW'(MY_ID);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    DISCARD
  } state_e;

  state_e        state_q;
  logic [LW-1:0] cnt_q;
  logic [LW-1:0] len_q;
  logic          nak_q;
  logic          cmdr_q;
  logic [DW-1:0] datar_q;
  logic          nakr_q;
  logic          ferr_q;
  logic [7:0]    drop_q;

  logic [DW:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] level_q;

  logic [LW-1:0] hdr_dest;
  logic [LW-1:0] hdr_len;
  logic [CW-1:0] free;
  logic          fits;
  logic          push;
  logic          pop;
  logic [DW:0]   head;

  assign hdr_dest = DataW[DW-1:LW];
  assign hdr_len  = DataW[LW-1:0];
  // Reservation uses the pre-edge level; a pop in this cycle is ignored.
  assign free     = CW'(DEPTH) - level_q;
  assign fits     = (32'(hdr_len) <= 32'(free));
  assign push     = (state_q == PAYLOAD);
  assign pop      = out_valid & out_ready;
  assign head     = mem_q[rptr_q];

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? head[DW-1:0] : '0;
  assign out_last  = out_valid & head[DW];
  assign level     = level_q;
  assign CmdR      = cmdr_q;
  assign DataR     = datar_q;
  assign NakR      = nakr_q;
  assign frame_err = ferr_q;
  assign drop_cnt  = drop_q;

  // Deframing FSM with registered response and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      nak_q   <= 1'b0;
      cmdr_q  <= 1'b0;
      datar_q <= '0;
      nakr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      cmdr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (CmdW) begin
            len_q <= hdr_len;
            cnt_q <= hdr_len;
            if (hdr_dest != ID) begin
              nak_q <= 1'b0;
              if (hdr_len != '0) state_q <= DISCARD;
            end else if (hdr_len == '0) begin
              cmdr_q  <= 1'b1;
              datar_q <= {ID, hdr_len};
              nakr_q  <= 1'b0;
            end else if (fits) begin
              state_q <= PAYLOAD;
            end else begin
              nak_q   <= 1'b1;
              state_q <= DISCARD;
              if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            end
          end
        end
        PAYLOAD: begin
          cnt_q <= cnt_q - LW'(1);
          if (CmdW) ferr_q <= 1'b1;
          if (cnt_q == LW'(1)) begin
            state_q <= IDLE;
            cmdr_q  <= 1'b1;
            datar_q <= {ID, len_q};
            nakr_q  <= 1'b0;
          end
        end
        DISCARD: begin
          cnt_q <= cnt_q - LW'(1);
          if (CmdW) ferr_q <= 1'b1;
          if (cnt_q == LW'(1)) begin
            state_q <= IDLE;
            nak_q   <= 1'b0;
            if (nak_q) begin
              cmdr_q  <= 1'b1;
              datar_q <= {ID, len_q};
              nakr_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO storage; no reset needed since empty entries are masked.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {cnt_q == LW'(1), DataW};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + CW'(1);
        2'b01:   level_q <= level_q - CW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: doc/noc_rx_endpoint.md
# noc_rx_endpoint

Parametrised receive endpoint for the device-side NoC bus. It deframes header-plus-payload packets arriving on CmdW/DataW and filters them by destination ID. Accepted payloads are buffered in a first-word-fall-through FIFO with a valid/ready output, and each addressed packet is acknowledged (ACK/NAK) on CmdR/DataR. It generalises the fixed 8-bit, unbuffered device bus to any even data width, with buffering, backpressure and a response channel.

## Interface
- DW, 8: data word width; must be even, ≥4. LW = DW/2 (ID and length field width).
- DEPTH, 16: FIFO depth in words, power of 2, ≥2. CW = $clog2(DEPTH)+1.
- MY_ID, 0: this endpoint's LW-bit destination ID.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- CmdW  in  1  1 = DataW holds a header word.
- DataW  in  DW  header {dest[DW-1:LW], len[LW-1:0]} or payload word.
- CmdR  out  1  one-cycle response strobe.
- DataR  out  DW  response word {MY_ID, len}, valid with CmdR.
- NakR  out  1  1 = packet dropped; valid with CmdR.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer pops when out_valid & out_ready.
- out_data  out  DW  head-of-FIFO payload word.
- out_last  out  1  head word is the final word of its packet.
- level  out  CW  FIFO occupancy, 0..DEPTH.
- frame_err  out  1  sticky framing-error flag.
- drop_cnt  out  8  count of NAK'd packets, saturates at 255.

## Operation
- FSM states: IDLE, PAYLOAD, DISCARD; reset → IDLE.
- IDLE, CmdW=1, header word:
  - dest≠MY_ID: enter DISCARD (silent); if len=0, stay IDLE.
  - dest=MY_ID, len=0: issue ACK next cycle; stay IDLE.
  - dest=MY_ID, len≤DEPTH−level (level sampled before this edge): reserve space; enter PAYLOAD with remaining count = len.
  - dest=MY_ID, len>DEPTH−level: enter DISCARD (NAK pending); drop_cnt+1.
- IDLE, CmdW=0: word ignored; no flag set.
- PAYLOAD: every cycle, push DataW and decrement the count. The word with count=1 is pushed with last=1, ACK is issued, and the FSM returns to IDLE.
  - CmdW=1 in PAYLOAD is not a header. The word is pushed as payload and frame_err is set.
- DISCARD: count down len words without pushing. On the final word return to IDLE, issuing NAK if one is pending.
  - CmdW=1 in DISCARD sets frame_err.
- Response word: DataR = {MY_ID, len of the header}. ACK → NakR=0; NAK → NakR=1.
- Packets with len>DEPTH are always NAK'd.
- FIFO storage is DW+1 bits ({last, data}). Pop on out_valid & out_ready. Reservation guarantees a push never meets a full FIFO. Simultaneous push and pop leaves level unchanged.
- Header reservation is conservative: a pop in the header cycle is not counted.
- frame_err and drop_cnt clear only on reset.

## Timing
- Reset values: CmdR=0, DataR=0, NakR=0, out_valid=0, out_last=0, out_data=0 (memory read of empty FIFO is masked to 0), level=0, frame_err=0, drop_cnt=0.
- Reset asserted mid-packet aborts the packet: FIFO is emptied and any pending response is lost.
- Payload word sampled at edge t appears on out_data with out_valid=1 after edge t (zero extra latency when the FIFO was empty).
- ACK/NAK: CmdR=1 for exactly one cycle after the edge that sampled the final payload word (len>0) or the header (len=0).
- A new header may arrive in the cycle immediately after a packet's final word. Its own response never overlaps the previous one, since responses are ≥1 cycle apart.
- Both CmdR and level are registered outputs.

## Test plan
- DW=8, DEPTH=16, MY_ID=3. Header 8'h33, then payload AA, BB, CC; out_ready=1 → out_data AA, BB, CC on consecutive cycles, out_last only on CC. One cycle after CC: CmdR=1, DataR=8'h33, NakR=0.
- Header 8'h52, then two payload words → level stays 0, CmdR stays 0, drop_cnt=0.
- out_ready=0. Header 8'h3C with 12 words → level=12 and ACK. Then header 8'h35 with 5 words → nothing pushed, level=12. One cycle after the 5th word: CmdR=1, DataR=8'h35, NakR=1, and drop_cnt=1.
- Header 8'h30 → CmdR=1 with DataR=8'h30 one cycle later; level unchanged.
- Header 8'h32, then word 11 with CmdW=0, then word 31 with CmdW=1 → both words pushed, last on 31, frame_err=1, ACK with DataR=8'h32.
- Assert rst after the 1st word of an 8'h34 packet → all outputs at their reset values. After release, header 8'h31 plus one word is received and ACK'd normally.
